parallel_to_serial: RTL
=======================

Name: parallel_to_serial

Overview:
- Transmit-side counterpart of the serial-to-parallel receiver.
- Accepts a width-bit word over a valid/ready handshake and emits it one bit per transfer, LSB first, with valid/ready flow control on the serial side.
- A one-word holding buffer lets back-to-back words stream with no idle cycle between them.
- Sits between a word producer and a serial link whose receiver reassembles bit 0 first.

Parameters:
width, 8, bits per parallel word (>= 2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous reset, active-low (asserted when 0)
parallel_valid  input  1  producer offers parallel_data
parallel_ready  output  1  block can accept a word this cycle
parallel_data  input  width  word to serialise
serial_valid  output  1  serial_data holds a valid bit
serial_ready  input  1  consumer takes the bit this cycle
serial_data  output  1  current bit
serial_last  output  1  current bit is bit width-1 of its word

Behaviour:
- Reset (rst=0, async): state IDLE, shifter/buffer/count cleared, buffer empty.
  - Outputs at reset: serial_valid=0, serial_data=0, serial_last=0, parallel_ready=1 (ready is combinational from buffer-empty, so it reads 1 while rst is asserted).
  - Reset mid-word discards all in-flight and buffered data; no partial word is resumed.
- Input handshake:
  - Word accepted on an edge where parallel_valid && parallel_ready.
  - parallel_ready = !buf_full. Combinational from state only, never from parallel_valid.
- Serial handshake:
  - Bit transferred on an edge where serial_valid && serial_ready.
  - serial_data and serial_last are stable while serial_valid=1 and serial_ready=0.
- States:
  - IDLE: serial_valid=0. Accepted word loads the shifter, count=0, go SHIFT. Latency: first bit valid on the cycle after acceptance.
  - SHIFT: serial_valid=1, serial_data=shifter[0], serial_last=(count==width-1).
    - On transfer with count<width-1: shift right, count+1.
    - On transfer with count==width-1 (last bit):
      - buffer full: load buffer into shifter, clear buffer, count=0, stay SHIFT (no bubble).
      - else if a word is accepted on the same edge: load it directly into shifter, stay SHIFT.
      - else: go IDLE.
- Buffering: a word accepted in SHIFT goes to the buffer unless it is loaded directly under the last-bit rule above.
- Simultaneous events:
  - Buffer full, last bit transferring, producer offering: not accepted (ready=0). Buffer moves to shifter; ready=1 next cycle.
  - Accept and non-last bit transfer on the same edge: both take effect.
- Count width: $clog2(width) bits; it never wraps past width-1.
- Output bit order: bit 0 first, so a serial_to_parallel of equal width reconstructs the identical word.

Decomposition:
- Shared package p2s_pkg:
  - state enum (IDLE, SHIFT)
  - localparam helper for count width
- One natural sub-module, p2s_hold_buffer: the one-entry register holding the word, full flag, load and pop controls.
- Shifter, counter and FSM stay in the top module.

Test Plan:
- Single word: rst pulse; offer 8'hA5, serial_ready=1.
  -> parallel_ready=1; starting one cycle later, serial bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles; serial_last only on the 8th; then serial_valid=0.
- Back-to-back: offer 8'h01 then 8'hFF, serial_ready=1.
  -> 16 consecutive valid bits with no gap (1,0×7,1×8); parallel_ready drops while the buffer is full and rises on the cycle after the last bit of word 1.
- Backpressure: offer 8'h3C, hold serial_ready=0 for 5 cycles at bit 2, then 1.
  -> serial_data holds 1 (bit 2 of 8'h3C) with serial_valid=1 throughout; total 8 transfers, order unchanged.
- Full-buffer collision: shifter on its last bit, buffer holds 8'h55, producer offers 8'hAA.
  -> 8'hAA not taken that edge; 8'h55 streams next; 8'hAA is accepted one cycle later and follows 8'h55.
- Mid-word reset: rst=0 asynchronously after 3 bits of 8'hF0.
  -> serial_valid=0 immediately; after release, a new word 8'h81 streams cleanly with no stale bits.
- Loopback: chain into serial_to_parallel (width=8) with serial_ready=1; 100 random words.
  -> every parallel word received equals the one sent, in order.

Source files
------------

// File: rtl/p2s_pkg.sv
// Shared types and sizing helpers for the parallel-to-serial transmitter.
package p2s_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } p2s_state_e;

   function automatic int unsigned cnt_w(input int unsigned w);
      return (w < 32'd2) ? 32'd1 : $clog2(w);
   endfunction

endpackage : p2s_pkg

// File: rtl/p2s_hold_buffer.sv
// One-entry holding register that lets the next word wait while the shifter drains.
module p2s_hold_buffer
   import p2s_pkg::*;
#(
   parameter int unsigned width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             pop_i,
   input  logic [width-1:0] data_i,
   output logic [width-1:0] data_o,
   output logic             full_o
);

   logic [width-1:0] data_q;
   logic             full_q;

   // Pop wins over load; the two never coincide because load requires an empty buffer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q <= '0;
         full_q <= 1'b0;
      end else if (pop_i) begin
         data_q <= '0;
         full_q <= 1'b0;
      end else if (load_i) begin
         data_q <= data_i;
         full_q <= 1'b1;
      end else begin
         data_q <= data_q;
         full_q <= full_q;
      end
   end

   assign data_o = data_q;
   assign full_o = full_q;

endmodule : p2s_hold_buffer

// File: rtl/parallel_to_serial.sv
// Serialises width-bit words LSB first with valid/ready on both sides;
// a one-word buffer keeps consecutive words streaming without a bubble.
module parallel_to_serial
   import p2s_pkg::*;
#(
   parameter int unsigned width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             parallel_valid,
   output logic             parallel_ready,
   input  logic [width-1:0] parallel_data,
   output logic             serial_valid,
   input  logic             serial_ready,
   output logic             serial_data,
   output logic             serial_last
);

   localparam int unsigned    CW       = cnt_w(width);
   localparam logic [CW-1:0]  CNT_LAST = CW'(width - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

   p2s_state_e       state_q, state_d;
   logic [width-1:0] shift_q, shift_d;
   logic [CW-1:0]    count_q, count_d;

   logic             buf_full_s;
   logic             buf_load_s;
   logic             buf_pop_s;
   logic [width-1:0] buf_data_s;
   logic             accept_s;
   logic             xfer_s;
   logic             last_s;

   p2s_hold_buffer #(.width(width)) u_hold (
      .clk    (clk),
      .rst    (rst),
      .load_i (buf_load_s),
      .pop_i  (buf_pop_s),
      .data_i (parallel_data),
      .data_o (buf_data_s),
      .full_o (buf_full_s)
   );

   assign parallel_ready = !buf_full_s;
   assign accept_s       = parallel_valid && !buf_full_s;
   assign xfer_s         = (state_q == SHIFT) && serial_ready;
   assign last_s         = (count_q == CNT_LAST);

   assign serial_valid   = (state_q == SHIFT);
   assign serial_data    = serial_valid & shift_q[0];
   assign serial_last    = serial_valid & last_s;

   // State, shifter and bit counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         count_q <= count_d;
      end
   end

   // Next-state logic: the last-bit edge refills from the buffer first, then straight from the producer.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      count_d    = count_q;
      buf_load_s = 1'b0;
      buf_pop_s  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               shift_d = parallel_data;
               count_d = '0;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            if (xfer_s && !last_s) begin
               shift_d    = shift_q >> 1;
               count_d    = count_q + CNT_ONE;
               buf_load_s = accept_s;
            end else if (xfer_s) begin
               count_d = '0;
               if (buf_full_s) begin
                  shift_d   = buf_data_s;
                  buf_pop_s = 1'b1;
               end else if (accept_s) begin
                  shift_d = parallel_data;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               buf_load_s = accept_s;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule : parallel_to_serial
